// File: rtl/weights_ram_srv_if.sv
// Host-load and accelerator-read signal bundle for weights_ram_srv.
// The master modport is the host/accelerator side; the slave modport is the RAM server.
interface weights_ram_srv_if #(
  parameter int VIRTEX_DWIDTH    = 16,
  parameter int PIPE_WIDTH       = 4,
  parameter int VIRTEX_NUM_WIDTH = 5,
  parameter int VIRTEX_AWIDTH    = 6
);
  logic                                  load_start_i;
  logic [VIRTEX_NUM_WIDTH-1:0]           load_virt_num_i;
  logic                                  load_valid_i;
  logic [VIRTEX_DWIDTH-1:0]              load_data_i;
  logic                                  load_ready_o;
  logic                                  load_done_o;
  logic                                  load_err_o;
  logic                                  rd_cs_i;
  logic [VIRTEX_AWIDTH-1:0]              rd_addr_i;
  logic [VIRTEX_DWIDTH*PIPE_WIDTH-1:0]   rd_data_o;
  logic                                  rd_vld_o;
  logic                                  rd_err_o;

  modport master (
    output load_start_i, load_virt_num_i, load_valid_i, load_data_i,
    output rd_cs_i, rd_addr_i,
    input  load_ready_o, load_done_o, load_err_o,
    input  rd_data_o, rd_vld_o, rd_err_o
  );

  modport slave (
    input  load_start_i, load_virt_num_i, load_valid_i, load_data_i,
    input  rd_cs_i, rd_addr_i,
    output load_ready_o, load_done_o, load_err_o,
    output rd_data_o, rd_vld_o, rd_err_o
  );
endinterface

// File: rtl/weights_ram_srv.sv
// Weights-RAM responder: packs streamed weights into PIPE_WIDTH rows, serves reads with 1-cycle latency;
// load_ready_o is the only backpressure (high in LOAD). WEIGHTS_SATURATE_EN maps negative weights to all-ones.
module weights_ram_srv #(
  parameter int VIRTEX_DWIDTH    = 16,
  parameter int PIPE_WIDTH       = 4,
  parameter int PIPE_SHIFT       = 2,
  parameter int MAX_VIRTEX_NUM   = 16,
  parameter int VIRTEX_NUM_WIDTH = 5,
  parameter int VIRTEX_AWIDTH    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  weights_ram_srv_if.slave      bus
);

  localparam int DW   = VIRTEX_DWIDTH;
  localparam int PW   = PIPE_WIDTH;
  localparam int NW   = VIRTEX_NUM_WIDTH;
  localparam int AW   = VIRTEX_AWIDTH;
  localparam int RW   = DW * PW;
  localparam int ROWS = 1 << AW;
  localparam int CW   = (2 * NW > AW) ? 2 * NW : AW + 1;
  localparam logic [PIPE_SHIFT-1:0] LANE_LAST = PIPE_SHIFT'(PW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [PIPE_SHIFT-1:0] lane_q, lane_d;
  logic [AW-1:0]         row_q, row_d;
  logic [DW-1:0]         buf_q [PW-1];
  logic [DW-1:0]         buf_d [PW-1];
  logic                  load_ready_q, load_ready_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_err_q, rd_err_d;
  logic [RW-1:0]         rd_data_q, rd_data_d;

  logic [RW-1:0]         ram [ROWS];
  logic                  ram_we;
  logic [RW-1:0]         ram_wdata;

  logic [DW-1:0]         store_word;
  logic [2*NW-1:0]       n_sq;
  logic [CW-1:0]         rows_total;
  logic [CW-1:0]         last_row;
  logic                  n_ok;
  logic                  hs;
  logic                  rd_bad;

  // Saturated negatives read as "infinite" to the accelerator's unsigned min-compare.
`ifdef WEIGHTS_SATURATE_EN
  assign store_word = bus.load_data_i[DW-1] ? {DW{1'b1}} : bus.load_data_i;
`else
  assign store_word = bus.load_data_i;
`endif

  assign n_sq       = {{NW{1'b0}}, n_q} * {{NW{1'b0}}, n_q};
  assign rows_total = CW'(n_sq >> PIPE_SHIFT);
  assign last_row   = rows_total - 1'b1;

  assign n_ok = (bus.load_virt_num_i != '0) &&
                (32'(bus.load_virt_num_i) <= MAX_VIRTEX_NUM) &&
                (bus.load_virt_num_i[PIPE_SHIFT-1:0] == '0);

  assign hs     = bus.load_valid_i && load_ready_q;
  assign rd_bad = (state_q == LOAD) || (CW'(bus.rd_addr_i) >= rows_total);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    lane_d       = lane_q;
    row_d        = row_q;
    buf_d        = buf_q;
    load_ready_d = load_ready_q;
    load_done_d  = 1'b0;
    load_err_d   = 1'b0;
    ram_we       = 1'b0;
    ram_wdata    = '0;

    for (int i = 0; i < PW - 1; i++) begin
      ram_wdata[i*DW +: DW] = buf_q[i];
    end
    ram_wdata[(PW-1)*DW +: DW] = store_word;

    case (state_q)
      IDLE: begin
        if (bus.load_start_i) begin
          if (n_ok) begin
            n_d          = bus.load_virt_num_i;
            lane_d       = '0;
            row_d        = '0;
            load_ready_d = 1'b1;
            state_d      = LOAD;
          end else begin
            load_done_d = 1'b1;
            load_err_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          if (lane_q == LANE_LAST) begin
            ram_we = 1'b1;
            lane_d = '0;
            row_d  = row_q + 1'b1;
            if (CW'(row_q) == last_row) begin
              load_ready_d = 1'b0;
              load_done_d  = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            for (int i = 0; i < PW - 1; i++) begin
              if (lane_q == PIPE_SHIFT'(i)) buf_d[i] = store_word;
            end
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads sample the pre-edge state, so a read in the same cycle as load_start_i is served normally.
  always_comb begin
    rd_vld_d  = bus.rd_cs_i;
    rd_err_d  = bus.rd_cs_i && rd_bad;
    rd_data_d = rd_data_q;
    if (bus.rd_cs_i) begin
      rd_data_d = rd_bad ? '0 : ram[bus.rd_addr_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      lane_q       <= '0;
      row_q        <= '0;
      for (int i = 0; i < PW - 1; i++) buf_q[i] <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      lane_q       <= lane_d;
      row_q        <= row_d;
      buf_q        <= buf_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      rd_vld_q     <= rd_vld_d;
      rd_err_q     <= rd_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // RAM contents survive reset; stored N=0 makes every row unreadable until a load completes.
  always_ff @(posedge clk) begin
    if (ram_we) ram[row_q] <= ram_wdata;
  end

  assign bus.load_ready_o = load_ready_q;
  assign bus.load_done_o  = load_done_q;
  assign bus.load_err_o   = load_err_q;
  assign bus.rd_vld_o     = rd_vld_q;
  assign bus.rd_err_o     = rd_err_q;
  assign bus.rd_data_o    = rd_data_q;

endmodule
